uart_crc_frame_tx: RTL and testbench
====================================

Name: uart_crc_frame_tx

Overview:
- Transmit-side counterpart to the UART receive plus CRC8 path.
- Buffers bytes delivered by upstream logic, e.g. an interfpga_receive output or a pushbutton-driven source.
- On a send pulse, serialises the buffered bytes as 8N1 UART on o_tx, then appends one CRC8 byte computed over them.
- A far-end uart_receiver plus crc instance over data+CRC ends at 0x00; its displayed CRC over data bytes alone equals o_8_crc8.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); minimum 2.
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (default 16).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
i_8_data  in  8  byte to enqueue.
i_push  in  1  one-cycle enqueue strobe (single_pulser output).
i_send  in  1  one-cycle "transmit frame" strobe.
o_tx  out  1  UART line, idle high.
o_busy  out  1  high from the cycle after an accepted send until the CRC stop bit completes.
o_full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
o_count  out  DEPTH_LOG2+1  bytes currently buffered.
o_drop  out  1  sticky: a push was discarded; cleared only by reset.
o_done  out  1  one-cycle pulse when the frame's last stop bit ends.
o_8_crc8  out  8  CRC8 over the data bytes of the current/last frame.

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: o_tx=1, o_busy=0, o_full=0, o_count=0, o_drop=0, o_done=0, o_8_crc8=0x00, FIFO empty, FSM in IDLE. Reset mid-frame takes effect next edge: line returns high immediately and the partial byte is abandoned.
- CRC8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR. Updated byte-wise when a byte is popped. o_8_crc8 clears to 0x00 on an accepted send and holds its final value after o_done until the next accepted send.
- UART: 1 start (0), 8 data LSB-first, 1 stop (1). Each bit is exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, LOAD, START, DATA, STOP, CRC_LOAD, DONE.
- IDLE:
  - i_send with o_count>0 -> LOAD.
  - i_send with o_count==0 is ignored: no line activity, busy stays 0.
- LOAD (1 cycle, tx=1): pop FIFO head into shift reg, update CRC -> START.
- START -> DATA -> STOP (bit counter 0..7).
- After STOP:
  - FIFO non-empty -> LOAD.
  - FIFO empty -> CRC_LOAD.
- CRC_LOAD (1 cycle): shift reg = updated CRC -> START. A frame flag marks this pass as the CRC byte.
- STOP of the CRC byte -> DONE (1 cycle, o_done=1, o_busy still 1) -> IDLE.
- Latency and framing:
  - i_send at cycle T -> LOAD at T+1, start-bit falling edge at T+2.
  - Each byte occupies 1 + 10*CLKS_PER_BIT cycles.
  - Frame of N data bytes is busy for (N+1)*(1+10*CLKS_PER_BIT)+1 cycles.
- Push rules:
  - Accepted only in IDLE with o_full=0.
  - A push while full or busy is dropped and sets o_drop.
  - Same-cycle i_push and i_send in IDLE: the byte is written and included in the frame; the send is also accepted with an empty FIFO if a push coincides.
  - i_send while busy is ignored; a frame is never re-triggered.
- FIFO pointers wrap mod 2**DEPTH_LOG2. o_count uses the extra bit to distinguish full from empty.

Decomposition:
- Package uart_crc_pkg holds:
  - state encoding constants;
  - CRC_POLY=8'h07 and CRC_INIT=8'h00;
  - function crc8_next(crc, byte), also reused by crc if refactored.
- One sub-module, byte_fifo: a synchronous FIFO with DEPTH_LOG2 parameter, push/pop/full/empty/count, synchronous active-high reset.
- The UART bit timer/shifter stays inline.

Test Plan (CLKS_PER_BIT=4, DEPTH_LOG2=4):
1. Assert reset 3 cycles -> o_tx=1, o_busy=0, o_count=0, o_8_crc8=0x00, o_drop=0. Pulse i_send -> no line activity for 100 cycles.
2. Push 0x01, pulse i_send at T:
   - o_tx falls at T+2;
   - wire decodes bytes 0x01, 0x07;
   - o_done at T+83;
   - o_8_crc8=0x07.
3. Push ASCII "123456789", send -> wire carries 31..39 then 0xF4; o_8_crc8=0xF4; the far-end crc over all 10 bytes gives 0x00.
4. Push 17 bytes 0x00..0x10:
   - o_full=1 after 16, 17th dropped, o_drop=1;
   - frame carries 0x00..0x0F plus CRC.
   Then push during busy -> dropped; i_send during busy -> no second frame.
5. Same-cycle i_push(0xA5)+i_send in IDLE with empty FIFO -> frame 0xA5 plus CRC8(0xA5) matching the package function.
6. Assert reset during the 3rd data bit of a frame:
   - o_tx=1 next cycle, o_count=0, o_busy=0;
   - o_8_crc8 returns to 0x00 and o_drop clears;
   - a following push 0x01 + send frame matches scenario 2.

Source files
------------

// File: rtl/uart_crc_frame_tx_pkg.sv
// Shared constants for the UART CRC8 frame transmitter: FSM state encoding,
// CRC8 polynomial/seed and the byte-wise CRC8 update function.
package uart_crc_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_CRC_LOAD = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // MSB-first CRC8, no reflection, no final XOR
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_crc_frame_tx_byte_fifo.sv
// Synchronous byte FIFO with 2**DEPTH_LOG2 entries; count carries one extra
// bit so a full FIFO is distinguishable from an empty one.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_s;
  logic                  pop_s;

  assign full    = count_r[DEPTH_LOG2];
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_crc_frame_tx.sv
// Buffers bytes and, on a send strobe, transmits them as 8N1 UART followed
// by one CRC8 byte computed over the data bytes.
module uart_crc_frame_tx
  import uart_crc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            i_8_data,
  input  logic                  i_push,
  input  logic                  i_send,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_drop,
  output logic                  o_done,
  output logic [7:0]            o_8_crc8
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [2:0]          state_r;
  logic [CW-1:0]       clk_cnt_r;
  logic [2:0]          bit_cnt_r;
  logic [7:0]          shift_r;
  logic [7:0]          crc_r;
  logic                crc_pass_r;
  logic                tx_r;
  logic                busy_r;
  logic                done_r;
  logic                drop_r;

  logic                push_ok_s;
  logic                pop_s;
  logic                bit_end_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [7:0]          fifo_head_s;
  logic [DEPTH_LOG2:0] fifo_count_s;

  assign push_ok_s = i_push & (state_r == ST_IDLE) & ~fifo_full_s;
  assign pop_s     = (state_r == ST_LOAD);
  assign bit_end_s = (clk_cnt_r == CNT_MAX);

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_ok_s),
    .pop     (pop_s),
    .wr_data (i_8_data),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign o_tx     = tx_r;
  assign o_busy   = busy_r;
  assign o_full   = fifo_full_s;
  assign o_count  = fifo_count_s;
  assign o_drop   = drop_r;
  assign o_done   = done_r;
  assign o_8_crc8 = crc_r;

  // Frame sequencer, bit timer and shifter; tx is registered one state ahead
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      clk_cnt_r  <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      crc_r      <= CRC_INIT;
      crc_pass_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      drop_r <= drop_r | (i_push & ~push_ok_s);
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // a coincident push makes an otherwise empty send valid
          if (i_send && (!fifo_empty_s || push_ok_s)) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
            crc_r   <= CRC_INIT;
          end
        end
        ST_LOAD: begin
          shift_r   <= fifo_head_s;
          crc_r     <= crc8_next(crc_r, fifo_head_s);
          tx_r      <= 1'b0;
          clk_cnt_r <= '0;
          state_r   <= ST_START;
        end
        ST_START: begin
          if (bit_end_s) begin
            clk_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= ST_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= '0;
            if (crc_pass_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (!fifo_empty_s) begin
              state_r <= ST_LOAD;
            end else begin
              state_r <= ST_CRC_LOAD;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        ST_CRC_LOAD: begin
          shift_r    <= crc_r;
          crc_pass_r <= 1'b1;
          tx_r       <= 1'b0;
          clk_cnt_r  <= '0;
          state_r    <= ST_START;
        end
        ST_DONE: begin
          busy_r     <= 1'b0;
          crc_pass_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          crc_pass_r <= 1'b0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_crc_frame_tx.sv
// Scoreboard bench for uart_crc_frame_tx: stimulus queues expected wire bytes,
// a UART-decoding monitor pops and compares them independently.
module tb_uart_crc_frame_tx;
  import uart_crc_pkg::*;

  localparam int C     = 4;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_8_data;
  logic        i_push;
  logic        i_send;
  logic        o_tx;
  logic        o_busy;
  logic        o_full;
  logic [DL:0] o_count;
  logic        o_drop;
  logic        o_done;
  logic [7:0]  o_8_crc8;

  int   n_pass = 0;
  int   n_checks = 0;
  int   rst_epoch = 0;
  bq_t  model_q;
  bq_t  exp_q;
  bq_t  rx_log;
  logic model_drop;

  uart_crc_frame_tx #(.CLKS_PER_BIT(C), .DEPTH_LOG2(DL)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_8_data (i_8_data),
    .i_push   (i_push),
    .i_send   (i_send),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_full   (o_full),
    .o_count  (o_count),
    .o_drop   (o_drop),
    .o_done   (o_done),
    .o_8_crc8 (o_8_crc8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset === 1'b1) rst_epoch <= rst_epoch + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Reference CRC: bit-serial polynomial division over the whole message
  function automatic logic [7:0] model_crc(input bq_t msg);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: decode 8N1 from the line, compare against the scoreboard
  initial begin : monitor
    logic [7:0] b;
    logic       start_bit;
    logic       stop_bit;
    int         ep;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && o_tx === 1'b0) begin
        ep = rst_epoch;
        repeat (C / 2) @(negedge clk);
        start_bit = o_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (C) @(negedge clk);
        stop_bit = o_tx;
        if (ep == rst_epoch) begin
          check("start_bit", {31'd0, start_bit}, 32'd0);
          check("stop_bit", {31'd0, stop_bit}, 32'd1);
          rx_log.push_back(b);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", b);
          end else begin
            check("wire_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    i_push   = 1'b1;
    i_8_data = b;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_drop = 1'b1;
    @(posedge clk); #1;
    i_push = 1'b0;
  endtask

  task automatic watch_idle(input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
  endtask

  task automatic send_and_check(input bit with_push, input logic [7:0] pb, input bit poke);
    bq_t        frame;
    logic [7:0] crc;
    int         n;
    int         lat;
    int         k;
    if (with_push) begin
      if (model_q.size() < DEPTH) model_q.push_back(pb);
      else model_drop = 1'b1;
    end
    i_send   = 1'b1;
    i_push   = with_push;
    i_8_data = pb;
    @(posedge clk); #1;
    i_send = 1'b0;
    i_push = 1'b0;
    if (model_q.size() == 0) begin
      check("empty_send_busy", {31'd0, o_busy}, 32'd0);
      watch_idle(100);
      return;
    end
    frame = model_q;
    model_q.delete();
    n   = frame.size();
    crc = model_crc(frame);
    foreach (frame[i]) exp_q.push_back(frame[i]);
    exp_q.push_back(crc);
    check("busy_t1", {31'd0, o_busy}, 32'd1);
    check("tx_high_load", {31'd0, o_tx}, 32'd1);
    @(posedge clk); #1;
    check("tx_fall_t2", {31'd0, o_tx}, 32'd0);
    lat = (n + 1) * (1 + 10 * C) + 1;
    k = 2;
    while (o_done !== 1'b1 && k < lat + 50) begin
      if (poke && k == 30) begin
        i_push     = 1'b1;
        i_8_data   = 8'hEE;
        i_send     = 1'b1;
        model_drop = 1'b1;
      end
      @(posedge clk); #1;
      i_push = 1'b0;
      i_send = 1'b0;
      k++;
    end
    check("done_latency", k, lat);
    check("crc_at_done", {24'd0, o_8_crc8}, {24'd0, crc});
    check("busy_at_done", {31'd0, o_busy}, 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, o_done}, 32'd0);
    check("busy_after_done", {31'd0, o_busy}, 32'd0);
    check("crc_hold", {24'd0, o_8_crc8}, {24'd0, crc});
    check("drop_flag", {31'd0, o_drop}, {31'd0, model_drop});
    check("count_after", o_count, model_q.size());
    check("scoreboard_drained", exp_q.size(), 0);
    if (poke) watch_idle(100);
  endtask

  initial begin : stim
    bq_t one;
    int  n;
    int  co;
    reset      = 1'b1;
    i_push     = 1'b0;
    i_send     = 1'b0;
    i_8_data   = 8'h00;
    model_drop = 1'b0;

    // 1: reset values, empty send ignored
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_tx", {31'd0, o_tx}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_count", o_count, 0);
    check("rst_crc", {24'd0, o_8_crc8}, 32'd0);
    check("rst_drop", {31'd0, o_drop}, 32'd0);
    check("rst_full", {31'd0, o_full}, 32'd0);
    send_and_check(1'b0, 8'h00, 1'b0);

    // 2: single byte 0x01
    push_byte(8'h01);
    check("count_one", o_count, 1);
    send_and_check(1'b0, 8'h00, 1'b0);
    check("crc_0x01", {24'd0, o_8_crc8}, 32'h07);

    // 3: "123456789" check value and far-end residue
    rx_log.delete();
    for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i));
    send_and_check(1'b0, 8'h00, 1'b0);
    check("crc_check_value", {24'd0, o_8_crc8}, 32'hF4);
    check("rx_len", rx_log.size(), 10);
    check("far_end_residue", {24'd0, model_crc(rx_log)}, 32'd0);

    // 4: fill, overflow, pokes while busy
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("full_at_16", {31'd0, o_full}, 32'd1);
    check("count_16", o_count, 16);
    check("no_drop_yet", {31'd0, o_drop}, 32'd0);
    push_byte(8'h10);
    check("drop_17th", {31'd0, o_drop}, 32'd1);
    check("count_still_16", o_count, 16);
    send_and_check(1'b0, 8'h00, 1'b1);

    // 5: same-cycle push and send with an empty FIFO
    send_and_check(1'b1, 8'hA5, 1'b0);
    one = {8'hA5};
    check("pkg_crc_a5", {24'd0, crc8_next(CRC_INIT, 8'hA5)}, {24'd0, model_crc(one)});
    check("dut_crc_a5", {24'd0, o_8_crc8}, {24'd0, crc8_next(CRC_INIT, 8'hA5)});

    // 6: reset during the third data bit
    push_byte(8'h01);
    push_byte(8'h55);
    push_byte(8'h80);
    i_send = 1'b1;
    @(posedge clk); #1;
    i_send = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    check("mid_busy", {31'd0, o_busy}, 32'd1);
    check("mid_crc", {24'd0, o_8_crc8}, 32'h07);
    check("mid_tx_bit2", {31'd0, o_tx}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    model_drop = 1'b0;
    check("abort_tx", {31'd0, o_tx}, 32'd1);
    check("abort_count", o_count, 0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_crc", {24'd0, o_8_crc8}, 32'd0);
    check("abort_drop", {31'd0, o_drop}, 32'd0);
    watch_idle(50);
    push_byte(8'h01);
    send_and_check(1'b0, 8'h00, 1'b0);
    check("after_abort_crc", {24'd0, o_8_crc8}, 32'h07);

    // 7: randomized frames
    for (int f = 0; f < 6; f++) begin
      n  = $urandom_range(1, 16);
      co = $urandom_range(0, 1);
      for (int j = 0; j < n - co; j++) push_byte(8'($urandom_range(0, 255)));
      check("count_before_send", o_count, model_q.size());
      send_and_check(co[0], 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
